// File: rtl/mem_arbiter_2p_if.sv
// Bundle of both requester ports and the memory-side port for the 2-port arbiter.
// slave faces the arbiter; master is the requesters/memory side.
interface mem_arbiter_2p_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m0_address,  m1_address;
    logic [DATA_W/8-1:0] m0_byteenable, m1_byteenable;
    logic                m0_read,     m1_read;
    logic                m0_write,    m1_write;
    logic [DATA_W-1:0]   m0_writedata, m1_writedata;
    logic                m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0]   m0_readdata, m1_readdata;
    logic                m0_readdatavalid, m1_readdatavalid;

    logic [ADDR_W-1:0]   mem_address;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W-1:0]   mem_writedata;
    logic                mem_clken;
    logic [DATA_W-1:0]   mem_readdata;
    logic                range_err;

    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken, range_err,
        input  mem_readdata
    );

    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken, range_err,
        output mem_readdata
    );
endinterface

// File: rtl/mem_arbiter_2p.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM
// with 1-cycle read latency and out-of-range access filtering.
module mem_arbiter_2p #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32000
) (
    input  logic            clk,
    input  logic            reset,
    mem_arbiter_2p_if.slave bus
);
    localparam int          BE_W    = DATA_W / 8;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    logic [1:0]                  req, gnt, wr;
    logic [1:0][ADDR_W-1:0]      addr;
    logic [1:0][BE_W-1:0]        be;
    logic [1:0][DATA_W-1:0]      wdata;

    logic        sel, granted, is_wr, in_range;
    logic [31:0] addr_ext;
    logic        last_grant, rd_pend, rd_owner, rd_oor, range_err_q;

    assign addr  = {bus.m1_address,    bus.m0_address};
    assign be    = {bus.m1_byteenable, bus.m0_byteenable};
    assign wdata = {bus.m1_writedata,  bus.m0_writedata};
    assign wr    = {bus.m1_write,      bus.m0_write};
    assign req   = {bus.m1_read | bus.m1_write, bus.m0_read | bus.m0_write};

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        gnt = '0;
        if (!reset) begin
            if (req[0] && (!req[1] || last_grant)) gnt[0] = 1'b1;
            else if (req[1])                       gnt[1] = 1'b1;
        end
    end

    assign sel      = gnt[1];
    assign granted  = |gnt;
    assign is_wr    = wr[sel];
    assign addr_ext = {{(32-ADDR_W){1'b0}}, addr[sel]};
    assign in_range = addr_ext < DEPTH_U;

    assign bus.m0_waitrequest = (req[0] & ~gnt[0]) | reset;
    assign bus.m1_waitrequest = (req[1] & ~gnt[1]) | reset;

    assign bus.mem_address    = granted ? addr[sel]  : '0;
    assign bus.mem_byteenable = granted ? be[sel]    : '0;
    assign bus.mem_writedata  = granted ? wdata[sel] : '0;
    assign bus.mem_chipselect = granted & in_range;
    assign bus.mem_write      = granted & in_range & is_wr;
    assign bus.mem_clken      = ~reset;
    assign bus.range_err      = range_err_q;

    // Response side: a pending read is suppressed while reset is held.
    assign bus.m0_readdatavalid = rd_pend & ~rd_owner & ~reset;
    assign bus.m1_readdatavalid = rd_pend &  rd_owner & ~reset;
    assign bus.m0_readdata = (!rd_owner && !rd_oor) ? bus.mem_readdata : '0;
    assign bus.m1_readdata = ( rd_owner && !rd_oor) ? bus.mem_readdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant  <= 1'b1;
            rd_pend     <= 1'b0;
            rd_owner    <= 1'b0;
            rd_oor      <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            if (granted) last_grant <= sel;
            rd_pend     <= granted & ~is_wr;
            rd_owner    <= sel;
            rd_oor      <= ~in_range;
            range_err_q <= granted & ~in_range;
        end
    end
endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed bench for mem_arbiter_2p: a per-cycle vector table plus hand
// sequences for byte-enable merge and reset-during-read.
module tb_mem_arbiter_2p;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    mem_arbiter_2p_if bus ();

    mem_arbiter_2p dut (.clk(clk), .reset(reset), .bus(bus));

    // Behavioural RAM: unwritten words read back as 0x1000_0000 + address.
    logic [31:0] mem_arr [int];

    function automatic logic [31:0] rdm(input int a);
        return mem_arr.exists(a) ? mem_arr[a] : 32'h1000_0000 + 32'(a);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_chipselect) begin
            if (bus.mem_write) begin
                logic [31:0] w;
                w = rdm(int'(bus.mem_address));
                for (int b = 0; b < 4; b++)
                    if (bus.mem_byteenable[b]) w[8*b +: 8] = bus.mem_writedata[8*b +: 8];
                mem_arr[int'(bus.mem_address)] = w;
            end else begin
                bus.mem_readdata <= rdm(int'(bus.mem_address));
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic r0, w0; logic [14:0] a0;
        logic r1, w1; logic [14:0] a1;
        logic wq0, wq1, cs, mw; logic [14:0] ma;
        logic v0; logic [31:0] d0;
        logic v1; logic [31:0] d1;
        logic rerr;
    } vec_t;

    function automatic vec_t mk(
        input logic r0, w0, input int a0, input logic r1, w1, input int a1,
        input logic wq0, wq1, cs, mw, input int ma,
        input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1,
        input logic rerr);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = 15'(a0); v.r1 = r1; v.w1 = w1; v.a1 = 15'(a1);
        v.wq0 = wq0; v.wq1 = wq1; v.cs = cs; v.mw = mw; v.ma = 15'(ma);
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.rerr = rerr;
        return v;
    endfunction

    task automatic drive(input logic r0, w0, input int a0, input logic r1, w1, input int a1,
                         input logic [3:0] be, input logic [31:0] wd);
        bus.m0_read = r0; bus.m0_write = w0; bus.m0_address = 15'(a0);
        bus.m1_read = r1; bus.m1_write = w1; bus.m1_address = 15'(a1);
        bus.m0_byteenable = be; bus.m1_byteenable = be;
        bus.m0_writedata = wd;  bus.m1_writedata = wd;
    endtask

    vec_t tbl [16];

    initial begin
        // Contention at 5/9, an 8-cycle alternating burst, then range errors.
        tbl[0]  = mk(1,0,5,     1,0,9,  0,1,1,0,5,     0,0,            0,0,            0);
        tbl[1]  = mk(0,0,0,     1,0,9,  0,0,1,0,9,     1,32'h10000005, 0,0,            0);
        tbl[2]  = mk(0,0,0,     0,0,0,  0,0,0,0,0,     0,0,            1,32'h10000009, 0);
        for (int i = 0; i < 8; i++)
            tbl[3+i] = mk(1,0,20, 1,0,40, i[0], ~i[0], 1, 0, i[0] ? 40 : 20,
                          (i > 0) && i[0],  32'h10000014,
                          (i > 0) && !i[0], 32'h10000028, 0);
        tbl[11] = mk(0,0,0,     0,0,0,  0,0,0,0,0,     0,0,            1,32'h10000028, 0);
        tbl[12] = mk(1,0,32000, 0,0,0,  0,0,0,0,32000, 0,0,            0,0,            0);
        tbl[13] = mk(0,1,32767, 0,0,0,  0,0,0,0,32767, 1,0,            0,0,            1);
        tbl[14] = mk(0,0,0,     0,0,0,  0,0,0,0,0,     0,0,            0,0,            1);
        tbl[15] = mk(0,0,0,     0,0,0,  0,0,0,0,0,     0,0,            0,0,            0);

        drive(0,0,0, 0,0,0, 4'hF, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wq0",   bus.m0_waitrequest, 1);
        chk("rst_wq1",   bus.m1_waitrequest, 1);
        chk("rst_clken", bus.mem_clken, 0);
        chk("rst_cs",    bus.mem_chipselect, 0);
        chk("rst_maddr", bus.mem_address, 0);
        chk("rst_rerr",  bus.range_err, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_clken", bus.mem_clken, 1);
        chk("post_wq0",   bus.m0_waitrequest, 0);
        chk("post_v0",    bus.m0_readdatavalid, 0);

        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            drive(tbl[i].r0, tbl[i].w0, int'(tbl[i].a0), tbl[i].r1, tbl[i].w1, int'(tbl[i].a1), 4'hF, 0);
            @(negedge clk);
            chk($sformatf("v%0d_wq0", i),  bus.m0_waitrequest,   tbl[i].wq0);
            chk($sformatf("v%0d_wq1", i),  bus.m1_waitrequest,   tbl[i].wq1);
            chk($sformatf("v%0d_cs", i),   bus.mem_chipselect,   tbl[i].cs);
            chk($sformatf("v%0d_mw", i),   bus.mem_write,        tbl[i].mw);
            chk($sformatf("v%0d_ma", i),   bus.mem_address,      tbl[i].ma);
            chk($sformatf("v%0d_v0", i),   bus.m0_readdatavalid, tbl[i].v0);
            chk($sformatf("v%0d_v1", i),   bus.m1_readdatavalid, tbl[i].v1);
            chk($sformatf("v%0d_rerr", i), bus.range_err,        tbl[i].rerr);
            if (tbl[i].v0) chk($sformatf("v%0d_d0", i), bus.m0_readdata, tbl[i].d0);
            if (tbl[i].v1) chk($sformatf("v%0d_d1", i), bus.m1_readdata, tbl[i].d1);
        end

        // Partial-byte write from m1, then read back the merged word.
        @(posedge clk); #1 drive(0,0,0, 0,1,100, 4'b0011, 32'hDEADBEEF);
        @(negedge clk);
        chk("bw_wq1", bus.m1_waitrequest, 0);
        chk("bw_mw",  bus.mem_write, 1);
        chk("bw_cs",  bus.mem_chipselect, 1);
        chk("bw_ma",  bus.mem_address, 100);
        chk("bw_be",  bus.mem_byteenable, 4'b0011);
        chk("bw_wd",  bus.mem_writedata, 32'hDEADBEEF);
        @(posedge clk); #1 drive(0,0,0, 1,0,100, 4'hF, 0);
        @(negedge clk);
        chk("bw_nov1", bus.m1_readdatavalid, 0);
        chk("bw_rdcs", bus.mem_chipselect, 1);
        chk("bw_rdmw", bus.mem_write, 0);
        @(posedge clk); #1 drive(0,0,0, 0,0,0, 4'hF, 0);
        @(negedge clk);
        chk("bw_v1", bus.m1_readdatavalid, 1);
        chk("bw_d1", bus.m1_readdata, 32'h1000BEEF);

        // Reset raised right after a read is accepted: the response must vanish.
        @(posedge clk); #1 drive(1,0,7, 0,0,0, 4'hF, 0);
        @(negedge clk);
        chk("rr_acc", bus.m0_waitrequest, 0);
        @(posedge clk); #1 reset = 1'b1; drive(1,0,7, 1,0,8, 4'hF, 0);
        @(negedge clk);
        chk("rr_v0",    bus.m0_readdatavalid, 0);
        chk("rr_wq0",   bus.m0_waitrequest, 1);
        chk("rr_wq1",   bus.m1_waitrequest, 1);
        chk("rr_cs",    bus.mem_chipselect, 0);
        chk("rr_ma",    bus.mem_address, 0);
        chk("rr_clken", bus.mem_clken, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rr_post_v0",   bus.m0_readdatavalid, 0);
        chk("rr_post_rerr", bus.range_err, 0);
        chk("rr_post_wq0",  bus.m0_waitrequest, 0);
        chk("rr_post_wq1",  bus.m1_waitrequest, 1);
        chk("rr_post_ma",   bus.mem_address, 7);
        @(posedge clk); #1 drive(0,0,0, 0,0,0, 4'hF, 0);
        @(negedge clk);
        chk("rr_fin_v0", bus.m0_readdatavalid, 1);
        chk("rr_fin_d0", bus.m0_readdata, 32'h10000007);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/mem_arbiter_2p.md
MEM_ARBITER_2P -- requirements
Module: mem_arbiter_2p

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, word address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter DEPTH, default 32000, number of implemented words.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have, for each requester n in {0,1}, these ports: mn_address in ADDR_W; mn_byteenable in DATA_W/8; mn_read in 1; mn_write in 1; mn_writedata in DATA_W; mn_waitrequest out 1; mn_readdata out DATA_W; mn_readdatavalid out 1.
REQ-007 SHALL have memory-side ports: mem_address out ADDR_W; mem_byteenable out DATA_W/8; mem_chipselect out 1; mem_write out 1; mem_writedata out DATA_W; mem_clken out 1; mem_readdata in DATA_W, valid one cycle after the address is presented.
REQ-008 SHALL have port range_err, out 1, a one-cycle pulse on an out-of-range access.

Function
REQ-009 Requester n requests when mn_read|mn_write; simultaneous mn_read&mn_write SHALL be treated as a write.
REQ-010 At most one requester SHALL be granted per cycle; a request is accepted in the cycle it is granted.
REQ-011 Arbitration SHALL be round-robin on register last_grant: when both request, grant the requester other than last_grant; with a single requester, grant it.
REQ-012 last_grant SHALL update to the granted index only in cycles with a grant.
REQ-013 mn_waitrequest SHALL equal (request_n & ~grant_n) | reset; it is 0 when requester n is idle.
REQ-014 A requester under waitrequest holds its command stable; the arbiter SHALL NOT latch a non-granted command.
REQ-015 On grant, mem_address, mem_byteenable, mem_writedata SHALL combinationally forward the granted requester's signals; otherwise drive 0.
REQ-016 mem_chipselect SHALL be 1 only for a granted, in-range access.
REQ-017 mem_write SHALL be 1 only for a granted, in-range write.
REQ-018 mem_clken SHALL be constant 1 except 0 during reset.
REQ-019 An access is in range iff address < DEPTH.
REQ-020 Read latency SHALL be exactly 1 cycle: a read accepted in cycle t SHALL assert mn_readdatavalid for exactly one cycle in t+1.
REQ-021 The read pipeline SHALL use registers rd_pend (1 bit), rd_owner (1 bit) and rd_oor (1 bit).
REQ-022 mn_readdata SHALL be mem_readdata when rd_owner==n and ~rd_oor, else 0.
REQ-023 Back-to-back reads from alternating requesters SHALL sustain one accept per cycle with responses in accept order.
REQ-024 An out-of-range write SHALL be dropped, with no mem_write, still acknowledged (waitrequest 0).
REQ-025 An out-of-range read SHALL return readdata 0 with readdatavalid at t+1.
REQ-026 range_err SHALL pulse in cycle t+1 for any out-of-range access accepted at t.
REQ-027 Writes SHALL produce no readdatavalid.

Reset
REQ-028 While reset is high: no grant; both waitrequests 1; all mem_* outputs 0.
REQ-029 On the cycle after reset: rd_pend, readdatavalid and range_err SHALL be 0.
REQ-030 After reset, last_grant SHALL be 1, so m0 wins the first contention.
REQ-031 A read accepted in the cycle reset asserts SHALL have its pending response discarded: no readdatavalid after reset.

Verification
REQ-032 Bench: reset released, m0 and m1 both read (addr 5, addr 9) and hold -> m0 granted first (m1_waitrequest=1), m0_readdatavalid at next cycle with word 5, then m1 granted, m1_readdatavalid next cycle with word 9.
REQ-033 Bench: both requesters issue continuous reads for 8 cycles -> grants alternate m0,m1,... with 4 accepts each, no idle cycle.
REQ-034 Bench: m1 writes 0xDEADBEEF to addr 100 with byteenable 4'b0011, then reads addr 100 -> low half 0xBEEF merged with prior contents, high half unchanged, readdatavalid 1 cycle after accept.
REQ-035 Bench: m0 reads addr 32000 -> mem_chipselect 0, m0_readdata 0, m0_readdatavalid 1 and range_err 1 next cycle; m0 writes addr 32767 -> no mem_write, range_err pulse.
REQ-036 Bench: reset asserted in the cycle a read is accepted -> no readdatavalid afterwards; first post-reset contention grants m0.
